// File: rtl/spi_sram_pkg.sv
// Shared types and constants for the SPI-to-SRAM bridge.
// Holds the FSM state enum, command codes and the address increment helper.
package spi_sram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WDATA,
      RFETCH,
      RDATA,
      IGNORE
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   // Increment an address of width w, wrapping to zero at the top.
   function automatic logic [31:0] addr_inc(
      input logic [31:0] a,
      input int unsigned w
   );
      logic [31:0] m;
      m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (a + 32'd1) & m;
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Oversampling synchroniser for the SPI pins.
// Produces clean sck rise/fall pulses and a cs_n falling-edge pulse.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic cs_n,
   input  logic sdi,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_fall,
   output logic cs_s,
   output logic sdi_s
);

   logic [SYNC_STAGES-1:0] sck_q;
   logic [SYNC_STAGES-1:0] cs_q;
   logic [SYNC_STAGES-1:0] sdi_q;
   logic                   sck_d;
   logic                   cs_d;

   // cs_n resets high so release of reset never looks like a select.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q <= '0;
         cs_q  <= '1;
         sdi_q <= '0;
         sck_d <= 1'b0;
         cs_d  <= 1'b1;
      end else begin
         sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
         cs_q  <= {cs_q[SYNC_STAGES-2:0], cs_n};
         sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
         sck_d <= sck_q[SYNC_STAGES-1];
         cs_d  <= cs_q[SYNC_STAGES-1];
      end
   end

   assign cs_s     = cs_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_q[SYNC_STAGES-1];
   assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
   assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
   assign cs_fall  = ~cs_s & cs_d;

endmodule

// File: rtl/spi_sram_bridge.sv
// SPI mode-0 slave bridging command/address/data frames onto a sync SRAM.
// Supports burst write and prefetching burst read with address wrap.
module spi_sram_bridge
   import spi_sram_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int CMD_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              sdi,
   output logic              sdo,
   output logic              sdo_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              cmd_err
);

   localparam int SW0 = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
   localparam int SW  = (SW0 > DATA_W) ? SW0 : DATA_W;
   localparam int CW  = $clog2(SW) + 1;

   logic              sck_rise;
   logic              sck_fall;
   logic              cs_fall;
   logic              cs_s;
   logic              sdi_s;

   state_t            state;
   state_t            nxt;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     lim;
   logic [SW-1:0]     rx_shift;
   logic [SW-1:0]     rx_next;
   logic [DATA_W-1:0] tx_shift;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] addr_nxt;
   logic [CMD_W-1:0]  cmd_val;
   logic              is_read;
   logic              fetched;
   logic              last;
   logic              cmd_ok;

   spi_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .sck      (sck),
      .cs_n     (cs_n),
      .sdi      (sdi),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .cs_fall  (cs_fall),
      .cs_s     (cs_s),
      .sdi_s    (sdi_s)
   );

   assign rx_next  = {rx_shift[SW-2:0], sdi_s};
   assign cmd_val  = rx_next[CMD_W-1:0];
   assign cmd_ok   = (cmd_val == CMD_W'(CMD_WRITE)) ||
                     (cmd_val == CMD_W'(CMD_READ));
   assign addr_nxt = ADDR_W'(addr_inc(32'(addr_reg), ADDR_W));
   assign mem_addr = addr_reg;

   always_comb begin
      lim = CW'(DATA_W - 1);
      if (state == CMD)
         lim = CW'(CMD_W - 1);
      else if (state == ADDR)
         lim = CW'(ADDR_W - 1);
   end

   // A deselect in the same clk as the final bit suppresses that bit.
   assign last = sck_rise & ~cs_s & (bit_cnt == lim);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (cs_s) begin
         nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (cs_fall) nxt = CMD;
            CMD:     if (last) nxt = cmd_ok ? ADDR : IGNORE;
            ADDR:    if (last) nxt = is_read ? RFETCH : WDATA;
            WDATA:   nxt = WDATA;
            RFETCH:  if (fetched) nxt = RDATA;
            RDATA:   if (last) nxt = RFETCH;
            IGNORE:  nxt = IGNORE;
            default: nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state != IDLE);
      sdo_oe = (state == RDATA);
      sdo    = sdo_oe & tx_shift[DATA_W-1];
      mem_re = (state == RFETCH) & ~fetched;
   end

   // RFETCH spends one clk strobing mem_re and one clk capturing mem_rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         addr_reg  <= '0;
         is_read   <= 1'b0;
         fetched   <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         cmd_err   <= 1'b0;
      end else begin
         mem_we  <= 1'b0;
         cmd_err <= 1'b0;
         if (mem_we)
            addr_reg <= addr_nxt;
         if (cs_s) begin
            bit_cnt <= '0;
            fetched <= 1'b0;
         end else begin
            unique case (state)
               CMD, ADDR, WDATA: begin
                  if (sck_rise) begin
                     rx_shift <= rx_next;
                     bit_cnt  <= last ? '0 : bit_cnt + CW'(1);
                  end
                  if (last && state == CMD) begin
                     is_read <= (cmd_val == CMD_W'(CMD_READ));
                     cmd_err <= ~cmd_ok;
                  end
                  if (last && state == ADDR)
                     addr_reg <= rx_next[ADDR_W-1:0];
                  if (last && state == WDATA) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= rx_next[DATA_W-1:0];
                  end
               end
               RFETCH: begin
                  fetched <= ~fetched;
                  if (fetched) begin
                     tx_shift <= mem_rdata;
                     bit_cnt  <= '0;
                  end
               end
               RDATA: begin
                  if (sck_rise)
                     bit_cnt <= last ? '0 : bit_cnt + CW'(1);
                  // The first fall of each word only presents the MSB.
                  if (sck_fall && bit_cnt != '0)
                     tx_shift <= tx_shift << 1;
                  if (last)
                     addr_reg <= addr_nxt;
               end
               default: bit_cnt <= '0;
            endcase
         end
      end
   end

endmodule
